// File: rtl/vga_pkg.sv
// Shared VGA defaults: timing constants, game-state encodings, colours and RGB565 slice points.
// Pure declarations, no latency and no flow control.
package vga_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FRONT_DEF  = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BACK_DEF   = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FRONT_DEF  = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BACK_DEF   = 33;

   function automatic int h_total(input int active, input int front, input int sync, input int back);
      return active + front + sync + back;
   endfunction

   function automatic int v_total(input int active, input int front, input int sync, input int back);
      return active + front + sync + back;
   endfunction

   localparam logic [2:0] ST_IMG     = 3'b010;
   localparam logic [2:0] ST_WHITE_A = 3'b001;
   localparam logic [2:0] ST_WHITE_B = 3'b100;
   localparam logic [2:0] ST_WHITE_C = 3'b101;

   localparam logic [11:0] COL_BLACK = 12'h000;
   localparam logic [11:0] COL_WHITE = 12'hFFF;
   localparam logic [11:0] COL_BG    = 12'hFCD;

   // Top nibble of each RGB565 field becomes the 4-bit channel.
   localparam int PIX_R_LSB = 12;
   localparam int PIX_G_LSB = 7;
   localparam int PIX_B_LSB = 1;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   function automatic logic is_white_state(input logic [2:0] st);
      return (st == ST_WHITE_A) || (st == ST_WHITE_B) || (st == ST_WHITE_C);
   endfunction

   function automatic logic in_rect(input logic [12:0] px, input logic [12:0] py,
                                    input logic [12:0] rx, input logic [12:0] ry,
                                    input logic [12:0] rw, input logic [12:0] rh);
      return (px >= rx) && (px < rx + rw) && (py >= ry) && (py < ry + rh);
   endfunction

endpackage

// File: rtl/vga_compositor_if.sv
// Bundle between game controller, image RAM and VGA pins; slave is the compositor side.
// Plain wires, no latency and no flow control.
interface vga_compositor_if #(
   parameter int N_OBJ  = 4,
   parameter int ADDR_W = 19
) ();
   logic [2:0]          state;
   logic [11:0]         img_x;
   logic [11:0]         img_y;
   logic [12*N_OBJ-1:0] obj_x;
   logic [12*N_OBJ-1:0] obj_y;
   logic [N_OBJ-1:0]    obj_hide;
   logic [12*N_OBJ-1:0] obj_color;
   logic [15:0]         pix_data;
   logic [ADDR_W-1:0]   img_addr;
   logic                img_rd_en;
   logic                hsync;
   logic                vsync;
   logic [3:0]          red;
   logic [3:0]          green;
   logic [3:0]          blue;
   logic                frame_start;

   modport master (
      output state, img_x, img_y, obj_x, obj_y, obj_hide, obj_color, pix_data,
      input  img_addr, img_rd_en, hsync, vsync, red, green, blue, frame_start
   );

   modport slave (
      input  state, img_x, img_y, obj_x, obj_y, obj_hide, obj_color, pix_data,
      output img_addr, img_rd_en, hsync, vsync, red, green, blue, frame_start
   );
endinterface

// File: rtl/vga_timing.sv
// VGA raster counters with raw sync/active flags (combinational from counters) and a registered frame_start.
// frame_start is high during the cycle hcnt=0, vcnt=V_ACTIVE; free-running, no backpressure.
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FRONT  = H_FRONT_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BACK   = H_BACK_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FRONT  = V_FRONT_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BACK   = V_BACK_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [11:0] hcnt_o,
   output logic [11:0] vcnt_o,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        active_o,
   output logic        frame_start_o
);
   localparam int H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

   localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
   localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FRONT);
   localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FRONT);
   localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FRONT + V_SYNC);

   logic [11:0] hcnt_q, hcnt_d;
   logic [11:0] vcnt_q, vcnt_d;
   logic        frame_start_q, frame_start_d;

   always_comb begin
      hcnt_d = hcnt_q + 12'd1;
      vcnt_d = vcnt_q;
      if (hcnt_q == H_LAST) begin
         hcnt_d = '0;
         vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 12'd1;
      end
      // Decoded from next-state so the flag lines up with the counters it describes.
      frame_start_d = (hcnt_d == '0) && (vcnt_d == V_ACT);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         frame_start_q <= 1'b0;
      end else begin
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hcnt_o        = hcnt_q;
   assign vcnt_o        = vcnt_q;
   assign hsync_o       = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
   assign vsync_o       = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
   assign active_o      = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
   assign frame_start_o = frame_start_q;

endmodule

// File: rtl/vga_compositor.sv
// Composites N_OBJ sprites over a RAM background image on internally generated VGA timing; RGB/sync lag counters by 3 cycles.
// No backpressure: pixel clock free-runs and image RAM must return data one cycle after img_rd_en.
module vga_compositor
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FRONT  = H_FRONT_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BACK   = H_BACK_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FRONT  = V_FRONT_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BACK   = V_BACK_DEF,
   parameter int N_OBJ    = 4,
   parameter int OBJ_W    = 40,
   parameter int OBJ_H    = 40,
   parameter int IMG_W    = 640,
   parameter int IMG_H    = 480,
   parameter int ADDR_W   = 19
) (
   input  logic            clk_vga_i,
   input  logic            rst_i,
   vga_compositor_if.slave vga_bus
);
   logic [11:0] hcnt, vcnt;
   logic        hsync0, vsync0, active0, frame_start;

   vga_timing #(
      .H_ACTIVE (H_ACTIVE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
      .V_ACTIVE (V_ACTIVE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK)
   ) u_timing (
      .clk_i         (clk_vga_i),
      .rst_i         (rst_i),
      .hcnt_o        (hcnt),
      .vcnt_o        (vcnt),
      .hsync_o       (hsync0),
      .vsync_o       (vsync0),
      .active_o      (active0),
      .frame_start_o (frame_start)
   );

   // Shadow copies only move during vertical blanking, so a frame never tears.
   logic [2:0]          sh_state_q;
   logic [11:0]         sh_img_x_q, sh_img_y_q;
   logic [12*N_OBJ-1:0] sh_obj_x_q, sh_obj_y_q, sh_obj_color_q;
   logic [N_OBJ-1:0]    sh_obj_hide_q;

   always_ff @(posedge clk_vga_i) begin
      if (rst_i) begin
         sh_state_q     <= '0;
         sh_img_x_q     <= '0;
         sh_img_y_q     <= '0;
         sh_obj_x_q     <= '0;
         sh_obj_y_q     <= '0;
         sh_obj_color_q <= '0;
         sh_obj_hide_q  <= '1;
      end else if (frame_start) begin
         sh_state_q     <= vga_bus.state;
         sh_img_x_q     <= vga_bus.img_x;
         sh_img_y_q     <= vga_bus.img_y;
         sh_obj_x_q     <= vga_bus.obj_x;
         sh_obj_y_q     <= vga_bus.obj_y;
         sh_obj_color_q <= vga_bus.obj_color;
         sh_obj_hide_q  <= vga_bus.obj_hide;
      end
   end

   logic [12:0] x13, y13, img_dx, img_dy;
   assign x13    = {1'b0, hcnt};
   assign y13    = {1'b0, vcnt};
   assign img_dx = x13 - {1'b0, sh_img_x_q};
   assign img_dy = y13 - {1'b0, sh_img_y_q};

   logic        obj_hit_d;
   logic [11:0] obj_col_d;

   // Walk from the highest index down so the lowest-index hit is the one left standing.
   always_comb begin
      obj_hit_d = 1'b0;
      obj_col_d = COL_BLACK;
      for (int i = N_OBJ - 1; i >= 0; i--) begin
         if (!sh_obj_hide_q[i] &&
             in_rect(x13, y13, {1'b0, sh_obj_x_q[12*i +: 12]}, {1'b0, sh_obj_y_q[12*i +: 12]},
                     13'(OBJ_W), 13'(OBJ_H))) begin
            obj_hit_d = 1'b1;
            obj_col_d = sh_obj_color_q[12*i +: 12];
         end
      end
   end

   logic              img_region;
   logic              img_rd_en_d, img_rd_en_q;
   logic [ADDR_W-1:0] img_addr_d, img_addr_q;

   assign img_region  = active0 && in_rect(x13, y13, {1'b0, sh_img_x_q}, {1'b0, sh_img_y_q},
                                           13'(IMG_W), 13'(IMG_H));
   assign img_rd_en_d = img_region && (sh_state_q == ST_IMG);
   assign img_addr_d  = img_rd_en_d ? ADDR_W'(img_dy) * ADDR_W'(IMG_W) + ADDR_W'(img_dx)
                                    : img_addr_q;

   logic        active1_q, hsync1_q, vsync1_q, obj_hit1_q;
   logic [11:0] obj_col1_q;
   logic        active2_q, hsync2_q, vsync2_q, obj_hit2_q, img2_q;
   logic [11:0] obj_col2_q;

   always_ff @(posedge clk_vga_i) begin
      if (rst_i) begin
         active1_q   <= 1'b0;
         hsync1_q    <= 1'b1;
         vsync1_q    <= 1'b1;
         obj_hit1_q  <= 1'b0;
         obj_col1_q  <= '0;
         img_rd_en_q <= 1'b0;
         img_addr_q  <= '0;
         active2_q   <= 1'b0;
         hsync2_q    <= 1'b1;
         vsync2_q    <= 1'b1;
         obj_hit2_q  <= 1'b0;
         obj_col2_q  <= '0;
         img2_q      <= 1'b0;
      end else begin
         active1_q   <= active0;
         hsync1_q    <= hsync0;
         vsync1_q    <= vsync0;
         obj_hit1_q  <= obj_hit_d;
         obj_col1_q  <= obj_col_d;
         img_rd_en_q <= img_rd_en_d;
         img_addr_q  <= img_addr_d;
         active2_q   <= active1_q;
         hsync2_q    <= hsync1_q;
         vsync2_q    <= vsync1_q;
         obj_hit2_q  <= obj_hit1_q;
         obj_col2_q  <= obj_col1_q;
         img2_q      <= img_rd_en_q;
      end
   end

   rgb444_t rgb_d, rgb_q;
   logic    hsync3_q, vsync3_q;
   logic    pix_unused;

   assign pix_unused = ^{vga_bus.pix_data[11], vga_bus.pix_data[6:5], vga_bus.pix_data[0]};

   always_comb begin
      rgb_d = rgb444_t'(COL_BG);
      if (!active2_q) begin
         rgb_d = rgb444_t'(COL_BLACK);
      end else if (obj_hit2_q) begin
         rgb_d = rgb444_t'(obj_col2_q);
      end else if (img2_q) begin
         rgb_d.r = vga_bus.pix_data[PIX_R_LSB +: 4];
         rgb_d.g = vga_bus.pix_data[PIX_G_LSB +: 4];
         rgb_d.b = vga_bus.pix_data[PIX_B_LSB +: 4];
      end else if (is_white_state(sh_state_q)) begin
         rgb_d = rgb444_t'(COL_WHITE);
      end
   end

   always_ff @(posedge clk_vga_i) begin
      if (rst_i) begin
         rgb_q    <= '0;
         hsync3_q <= 1'b1;
         vsync3_q <= 1'b1;
      end else begin
         rgb_q    <= rgb_d;
         hsync3_q <= hsync2_q;
         vsync3_q <= vsync2_q;
      end
   end

   assign vga_bus.img_addr    = img_addr_q;
   assign vga_bus.img_rd_en   = img_rd_en_q;
   assign vga_bus.hsync       = hsync3_q;
   assign vga_bus.vsync       = vsync3_q;
   assign vga_bus.red         = rgb_q.r;
   assign vga_bus.green       = rgb_q.g;
   assign vga_bus.blue        = rgb_q.b;
   assign vga_bus.frame_start = frame_start;

endmodule

// File: tb/tb_vga_compositor.sv
// Directed bench for vga_compositor on a shrunken raster (144x71 total, 128x64 active) with a RAM model.
module tb_vga_compositor;
   localparam int HA = 128, HF = 4, HS = 8, HB = 4;
   localparam int VA = 64,  VF = 2, VS = 2, VB = 3;
   localparam int HT  = HA + HF + HS + HB;
   localparam int VT  = VA + VF + VS + VB;
   localparam int FR  = HT * VT;
   localparam int FS0 = VA * HT;

   logic clk_vga = 1'b0;
   logic rst     = 1'b1;
   int   cyc     = 0;
   int   checks  = 0;
   int   errors  = 0;

   always #20 clk_vga = ~clk_vga;

   vga_compositor_if #(.N_OBJ(4), .ADDR_W(19)) vga_bus ();

   vga_compositor #(
      .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
      .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
      .N_OBJ (4), .OBJ_W (8), .OBJ_H (6), .IMG_W (128), .IMG_H (48), .ADDR_W (19)
   ) dut (
      .clk_vga_i (clk_vga),
      .rst_i     (rst),
      .vga_bus   (vga_bus)
   );

   logic [15:0] ram_q = 16'h0;
   always @(posedge clk_vga) if (vga_bus.img_rd_en) ram_q <= vga_bus.img_addr[15:0];
   assign vga_bus.pix_data = ram_q;

   // Cycle 0 is the first cycle after the last reset edge, so hcnt = cyc mod HT.
   always @(posedge clk_vga) cyc <= rst ? 0 : cyc + 1;

   function automatic int pc(input int f, input int x, input int y);
      return f * FR + y * HT + x + 3;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic at(input int n);
      do @(negedge clk_vga); while (cyc < n);
      if (cyc != n) begin
         errors++;
         $error("FAIL sched observed=%0d expected=%0d", cyc, n);
      end
   endtask

   task automatic set_obj(input int i, input int x, input int y, input logic [11:0] col);
      vga_bus.obj_x[12*i +: 12]     = 12'(x);
      vga_bus.obj_y[12*i +: 12]     = 12'(y);
      vga_bus.obj_color[12*i +: 12] = col;
   endtask

   function automatic logic [11:0] rgb();
      return {vga_bus.red, vga_bus.green, vga_bus.blue};
   endfunction

   initial begin
      vga_bus.state     = 3'b010;
      vga_bus.img_x     = 12'd0;
      vga_bus.img_y     = 12'd0;
      vga_bus.obj_x     = '0;
      vga_bus.obj_y     = '0;
      vga_bus.obj_color = '0;
      vga_bus.obj_hide  = 4'b1110;
      set_obj(0, 2, 2, 12'h0FF);

      rst = 1'b1;
      repeat (5) @(posedge clk_vga);
      @(negedge clk_vga);
      check("rst_rgb", 32'(rgb()), 32'h000);
      check("rst_hsync", 32'(vga_bus.hsync), 32'd1);
      check("rst_vsync", 32'(vga_bus.vsync), 32'd1);
      check("rst_rd_en", 32'(vga_bus.img_rd_en), 32'd0);
      check("rst_addr", 32'(vga_bus.img_addr), 32'd0);
      check("rst_fs", 32'(vga_bus.frame_start), 32'd0);
      rst = 1'b0;

      at(134);  check("hs_before", 32'(vga_bus.hsync), 32'd1);
      at(135);  check("hs_first", 32'(vga_bus.hsync), 32'd0);
      at(142);  check("hs_last", 32'(vga_bus.hsync), 32'd0);
      at(143);  check("hs_after", 32'(vga_bus.hsync), 32'd1);
      at(HT + 135); check("hs_line1", 32'(vga_bus.hsync), 32'd0);
      at(HT + 143); check("hs_line1_end", 32'(vga_bus.hsync), 32'd1);

      at(pc(0, 2, 2));     check("f0_obj_hidden", 32'(rgb()), 32'hFCD);
      at(pc(0, 3, 3) - 2); check("f0_img_off", 32'(vga_bus.img_rd_en), 32'd0);

      vga_bus.state    = 3'b000;
      vga_bus.obj_hide = 4'b1110;
      set_obj(0, 100, 50, 12'h0FF);

      at(FS0 - 1); check("fs0_pre", 32'(vga_bus.frame_start), 32'd0);
      at(FS0);     check("fs0", 32'(vga_bus.frame_start), 32'd1);
      at(FS0 + 1); check("fs0_post", 32'(vga_bus.frame_start), 32'd0);

      at(66 * HT + 2); check("vs_before", 32'(vga_bus.vsync), 32'd1);
      at(66 * HT + 3); check("vs_first", 32'(vga_bus.vsync), 32'd0);
      at(68 * HT + 2); check("vs_last", 32'(vga_bus.vsync), 32'd0);
      at(68 * HT + 3); check("vs_after", 32'(vga_bus.vsync), 32'd1);

      at(pc(1, 99, 50));  check("obj_left_out", 32'(rgb()), 32'hFCD);
      at(pc(1, 100, 50)); check("obj_topleft", 32'(rgb()), 32'h0FF);
      at(pc(1, 108, 50)); check("obj_right_out", 32'(rgb()), 32'hFCD);
      at(pc(1, 130, 50)); check("porch_black", 32'(rgb()), 32'h000);
      at(pc(1, 107, 55)); check("obj_botright", 32'(rgb()), 32'h0FF);
      at(pc(1, 100, 56)); check("obj_below_out", 32'(rgb()), 32'hFCD);

      vga_bus.state    = 3'b001;
      vga_bus.obj_hide = 4'b1010;
      set_obj(0, 60, 20, 12'hF00);
      set_obj(2, 60, 20, 12'h00F);

      at(FS0 + FR - 1); check("fs1_pre", 32'(vga_bus.frame_start), 32'd0);
      at(FS0 + FR);     check("fs1_period", 32'(vga_bus.frame_start), 32'd1);

      at(2 * FR + 5);
      vga_bus.obj_hide = 4'b1011;
      at(pc(2, 10, 10)); check("white_bg", 32'(rgb()), 32'hFFF);
      at(pc(2, 62, 22)); check("prio_low_idx", 32'(rgb()), 32'hF00);
      at(FS0 + 2 * FR);  check("fs2", 32'(vga_bus.frame_start), 32'd1);
      at(pc(3, 62, 22)); check("prio_hidden0", 32'(rgb()), 32'h00F);

      vga_bus.state    = 3'b010;
      vga_bus.obj_hide = 4'b1111;
      vga_bus.img_x    = 12'd10;
      vga_bus.img_y    = 12'd20;

      at(pc(4, 13, 19));     check("img_above_bg", 32'(rgb()), 32'hFCD);
      at(pc(4, 9, 22) - 2);
      check("img_left_rd_en", 32'(vga_bus.img_rd_en), 32'd0);
      check("img_addr_hold", 32'(vga_bus.img_addr), 32'd245);
      at(pc(4, 9, 22));      check("img_left_bg", 32'(rgb()), 32'hFCD);
      at(pc(4, 13, 22) - 2);
      check("img_rd_en", 32'(vga_bus.img_rd_en), 32'd1);
      check("img_addr_259", 32'(vga_bus.img_addr), 32'd259);
      at(pc(4, 13, 22));     check("img_pix_259", 32'(rgb()), 32'h021);
      at(pc(4, 13, 60) - 2); check("img_addr_5123", 32'(vga_bus.img_addr), 32'd5123);
      at(pc(4, 13, 60));     check("img_pix_5123", 32'(rgb()), 32'h181);

      vga_bus.state    = 3'b000;
      vga_bus.obj_hide = 4'b1110;
      set_obj(0, 100, 36, 12'h0F0);

      at(5 * FR + 32 * HT);
      set_obj(0, 30, 36, 12'h0F0);
      at(pc(5, 30, 40));  check("latch_old_new_x", 32'(rgb()), 32'hFCD);
      at(pc(5, 100, 40)); check("latch_old_x", 32'(rgb()), 32'h0F0);
      at(pc(6, 30, 40));  check("latch_next_new", 32'(rgb()), 32'h0F0);
      at(pc(6, 100, 40)); check("latch_next_old", 32'(rgb()), 32'hFCD);

      rst = 1'b1;
      repeat (2) @(posedge clk_vga);
      @(negedge clk_vga);
      check("midrst_rgb", 32'(rgb()), 32'h000);
      check("midrst_hsync", 32'(vga_bus.hsync), 32'd1);
      check("midrst_fs", 32'(vga_bus.frame_start), 32'd0);
      rst = 1'b0;
      at(pc(0, 30, 40)); check("midrst_hidden", 32'(rgb()), 32'hFCD);
      at(FS0);           check("midrst_fs_restart", 32'(vga_bus.frame_start), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_compositor.md
Name: vga_compositor

Overview:
- Parametrised successor to the single-image VGA display.
- Generates VGA timing internally and composites N_OBJ rectangular sprite objects over a positioned background image read from synchronous RAM.
- Object and image positions are frame-latched so updates never tear mid-frame.
- Outputs are fully registered RGB444 plus sync, with a fixed pipeline latency.
- Sits between the game-state controller and the board VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BACK, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FRONT, 10, vertical front porch
V_SYNC, 2, vsync pulse width
V_BACK, 33, vertical back porch
N_OBJ, 4, number of sprite objects (1..8)
OBJ_W, 40, object width in pixels
OBJ_H, 40, object height in pixels
IMG_W, 640, background image width
IMG_H, 480, background image height
ADDR_W, 19, image RAM address width

Ports:
clk_vga  in  1  pixel clock, 25.175 MHz
rst  in  1  synchronous reset, active-high
state  in  3  game state; 3'b010 = image shown
img_x  in  12  image origin x, active-area coordinates
img_y  in  12  image origin y
obj_x  in  12*N_OBJ  object i origin x in bits [12i+11:12i]
obj_y  in  12*N_OBJ  object i origin y
obj_hide  in  N_OBJ  1 = object i not drawn
obj_color  in  12*N_OBJ  object i colour, {R,G,B} 4 bits each
pix_data  in  16  RGB565 from image RAM, valid 1 cycle after img_rd_en
img_addr  out  ADDR_W  image RAM address
img_rd_en  out  1  image RAM read strobe
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
red  out  4  pixel red
green  out  4  pixel green
blue  out  4  pixel blue
frame_start  out  1  one-cycle pulse, shadow registers updated

Behaviour:
- Counters:
  - hcnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters.
  - vcnt increments when hcnt wraps; it runs 0..V_TOTAL-1 and wraps to 0.
- Line and frame layout:
  - Each line is active, then front porch, then sync, then back porch.
  - Sync is active when hcnt is in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC). The vertical window is analogous.
- frame_start:
  - Asserted for the cycle with hcnt=0 and vcnt=V_ACTIVE.
  - On that same edge, shadow registers capture img_x, img_y, obj_x, obj_y, obj_hide, obj_color and state.
  - Compositing uses only the shadow values. Input changes at any other time take effect at the next frame_start.
- Pipeline:
  - S0: counters.
  - S1: hit tests, img_addr and img_rd_en registered.
  - S2: RAM data returns; hit and sync are delayed to match.
  - S3: colour mux, output registers.
  - rgb, hsync and vsync all lag the counters by exactly 3 cycles, so sync and pixels stay aligned.
- Object hit: object i hits when !hide_i and x >= ox_i, x < ox_i+OBJ_W, y >= oy_i, y < oy_i+OBJ_H.
  - All comparisons are 13-bit unsigned, so no wrap-around occurs.
  - An object partly off-screen is clipped.
- Object priority: the lowest-index hitting object wins.
- Image region: x in [img_x, img_x+IMG_W) and y in [img_y, img_y+IMG_H), also clipped to the active area.
  - img_rd_en = region && shadow state==3'b010.
  - img_addr = (y-img_y)*IMG_W + (x-img_x).
  - img_addr holds its value when img_rd_en is low.
- Colour priority:
  1. Outside the active area: 0,0,0.
  2. Object hit: obj_color of the winning object. Objects draw over the image, unlike the previous generation.
  3. Image region with state==010: R=pix_data[15:12], G=pix_data[10:7], B=pix_data[4:1].
  4. State 001, 100 or 101: F,F,F.
  5. Otherwise: F,C,D.
- Reset values, applied on the first clk_vga edge with rst=1:
  - hcnt=vcnt=0; all pipeline stages cleared.
  - red, green, blue = 0; hsync = vsync = 1; frame_start = 0; img_rd_en = 0; img_addr = 0.
  - Shadow positions 0, obj_hide all 1, state 0.
- Reset asserted mid-frame aborts the frame; timing restarts at hcnt=vcnt=0.
- The first frame_start after reset occurs at vcnt=V_ACTIVE. Until then every object is hidden and the image is off.

Decomposition:
- Shared package vga_pkg holds:
  - default timing constants and H_TOTAL/V_TOTAL functions;
  - the state encodings ST_IMG=3'b010 and the white-background states;
  - background colour constants 12'hFFF and 12'hFCD;
  - the RGB565-to-444 slice positions.
- Sub-module vga_timing: counters, sync generation, active flag and frame_start. It is reusable by future display blocks.

Test Plan:
1. Reset: hold rst 5 cycles → rgb=0, hsync=vsync=1, img_rd_en=0; after release, first frame_start at cycle 480*800 (default timing).
2. Timing:
   - hsync low for exactly 96 cycles, starting 659 cycles after hcnt=0 (656+3).
   - Period 800; vsync low for 2 lines; frame 800*525 cycles.
3. Object boundary: obj0 at (100,50), colour 12'h0FF, visible →
   - pixels (100,50) and (139,89) are 0,F,F;
   - pixels (140,50), (99,50) and (100,90) are background.
4. Priority: obj0 colour 12'hF00 and obj2 colour 12'h00F both at (200,200) → pixel (210,210) is F,0,0. Setting obj_hide[0] takes effect after the next frame_start, giving 0,0,F.
5. Image: state=010, img origin (10,20), RAM model returns addr[15:0] →
   - pixel (13,22) issues img_addr=2*640+3=1283;
   - output colour is the sliced 1283 one read cycle later;
   - pixel (9,22) shows F,C,D.
6. Frame latch: change obj_x[0] from 100 to 300 at vcnt=240 → rows 240..479 of the current frame still show the object at x=100; the next frame shows it at x=300.
